miriscv_decode_stage: RTL and testbench
=======================================

MIRISCV_DECODE_STAGE -- requirements
Module: miriscv_decode_stage

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk_i  in  1  single clock, all state on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all held instructions.
- in_valid_i  in  1  fetch offers an instruction.
- in_ready_o  out  1  stage accepts; registered output.
- in_instr_i  in  32  RV32I instruction word.
- in_pc_i  in  32  PC of the instruction.
- out_valid_o  out  1  a decoded bundle is presented.
- out_ready_i  in  1  execute accepts the bundle.
- alu_op_o  out  4  ALU operator code from defines.v (ALU_ADD ... ALU_NE).
- a_sel_o  out  2  operand A source: 0 rs1, 1 PC, 2 zero.
- b_sel_o  out  2  operand B source: 0 rs2, 1 imm, 2 constant 4.
- imm_o  out  32  sign-extended immediate.
- rs1_o, rs2_o, rd_o  out  5 each  register indices.
- rd_we_o  out  1  register write enable.
- mem_req_o  out  1  load/store request.
- mem_we_o  out  1  store.
- mem_size_o  out  3  funct3 of the load/store.
- branch_o  out  1  conditional branch.
- jal_o  out  1  JAL.
- jalr_o  out  1  JALR.
- illegal_o  out  1  illegal instruction.
- pc_o  out  32  PC of the presented bundle.

Function
REQ-002 SHALL decode OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD and STORE; any other opcode, or an instr[1:0] value other than 2'b11, SHALL set illegal_o=1 and force rd_we_o, mem_req_o, branch_o, jal_o and jalr_o to 0.
REQ-003 SHALL decode funct7 other than 0x00 in OP, and other than 0x20 on SUB/SRA, as illegal; SLLI/SRLI/SRAI with instr[25]=1 SHALL be illegal.
REQ-004 SHALL map BRANCH funct3 to ALU_EQ/NE/LTS/GES/LTU/GEU; funct3 010 and 011 in BRANCH are illegal.
REQ-005 SHALL use ALU_ADD for LUI (a_sel=zero), AUIPC (a_sel=PC), LOAD, STORE, JAL and JALR; JAL and JALR SHALL use a_sel=PC and b_sel=4.
REQ-006 SHALL form the I, S, B, U and J immediates per the ISA with bit 31 as sign; imm_o SHALL be 0 for R-type.
REQ-007 SHALL force rd_we_o to 0 whenever rd=x0.
REQ-008 SHALL hold decoded bundles in a 2-entry skid buffer with states EMPTY, ONE, TWO; decode SHALL be performed on entry to the buffer, so all outputs come from registers.
REQ-009 A transfer occurs only when valid&ready are both high on the same edge; outputs SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-010 Transitions (in=input transfer, out=output transfer):
- EMPTY: in -> ONE.
- ONE: in&!out -> TWO; !in&out -> EMPTY; else ONE.
- TWO: out -> ONE.
REQ-011 in_ready_o SHALL be 1 exactly when the next state is not TWO.
REQ-012 out_valid_o SHALL be 1 exactly in states ONE and TWO.
REQ-013 Latency SHALL be 1 cycle from input transfer to out_valid_o.
REQ-014 Bundles SHALL leave in acceptance order.
REQ-015 flush_i SHALL move the state to EMPTY on the next edge, discard any same-cycle input transfer, and take priority over all other events.

Reset
REQ-016 When rst_i=1 at an edge, state SHALL become EMPTY, out_valid_o=0 and in_ready_o=1.
REQ-017 Reset SHALL clear all bundle outputs to 0 (including illegal_o=0, pc_o=0).
REQ-018 Reset mid-transfer SHALL drop all held bundles, and rst_i SHALL take priority over flush_i.

Structure
REQ-019 The ALU operator codes and the opcode/funct constants SHALL live in the shared defines.v.
REQ-020 The combinational instruction decoder SHALL be a sub-module, miriscv_decoder, instantiated once at the buffer input.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- 0x00500093 (ADDI x1,x0,5), out_ready_i=1 -> next cycle: alu_op=ALU_ADD, b_sel=1, imm=5, rd=1, rd_we=1.
- 0x402081B3 (SUB x3,x1,x2) -> alu_op=ALU_SUB, a_sel=0, b_sel=0, rd=3; 0x4030D093 (SRAI x1,x1,3) -> alu_op=ALU_SRA, imm=3.
- 0x00208463 (BEQ x1,x2,+8) -> branch=1, alu_op=ALU_EQ, imm=8, rd_we=0; 0x00000000 -> illegal=1, rd_we=0.
- out_ready_i=0, three back-to-back offers -> two accepted, in_ready_o=0 during the third; after release, PCs emerge in order.
- flush_i in state TWO with a concurrent offer -> next cycle out_valid_o=0, in_ready_o=1, nothing emitted.
- rst_i while in state ONE -> next cycle out_valid_o=0 and all outputs 0.

Source files
------------

// File: rtl/miriscv_decode_stage_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU operator codes,
// operand-select encodings, the decoded bundle layout and the buffer states.
package miriscv_decode_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned REG_W    = 5;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  // ALU operator codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLTS = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_LTS  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_GES  = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_LTU  = 4'd12;
  localparam logic [ALU_OP_W-1:0] ALU_GEU  = 4'd13;
  localparam logic [ALU_OP_W-1:0] ALU_EQ   = 4'd14;
  localparam logic [ALU_OP_W-1:0] ALU_NE   = 4'd15;

  localparam logic [SEL_W-1:0] A_SEL_RS1  = 2'd0;
  localparam logic [SEL_W-1:0] A_SEL_PC   = 2'd1;
  localparam logic [SEL_W-1:0] A_SEL_ZERO = 2'd2;
  localparam logic [SEL_W-1:0] B_SEL_RS2  = 2'd0;
  localparam logic [SEL_W-1:0] B_SEL_IMM  = 2'd1;
  localparam logic [SEL_W-1:0] B_SEL_FOUR = 2'd2;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [SEL_W-1:0]    a_sel;
    logic [SEL_W-1:0]    b_sel;
    logic [XLEN-1:0]     imm;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic                rd_we;
    logic                mem_req;
    logic                mem_we;
    logic [2:0]          mem_size;
    logic                branch;
    logic                jal;
    logic                jalr;
    logic                illegal;
    logic [XLEN-1:0]     pc;
  } decode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Base ALU operator for OP/OP-IMM by funct3 (funct7 alternates handled by caller)
  function automatic logic [ALU_OP_W-1:0] alu_op_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLTS;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_decoder.sv
// Combinational RV32I decoder.
// Ports: instr_i/pc_i - instruction word and its PC; dec_o - decoded bundle.
module miriscv_decoder
  import miriscv_decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output decode_t         dec_o
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            illegal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec_o        = '0;
    illegal      = 1'b0;
    dec_o.alu_op = ALU_ADD;
    dec_o.a_sel  = A_SEL_RS1;
    dec_o.b_sel  = B_SEL_RS2;
    dec_o.rs1    = instr_i[19:15];
    dec_o.rs2    = instr_i[24:20];
    dec_o.rd     = instr_i[11:7];
    dec_o.pc     = pc_i;

    if (instr_i[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec_o.alu_op = alu_op_from_funct3(funct3);
          dec_o.rd_we  = 1'b1;
          if (funct7 == FUNCT7_ALT && funct3 == 3'b000)      dec_o.alu_op = ALU_SUB;
          else if (funct7 == FUNCT7_ALT && funct3 == 3'b101) dec_o.alu_op = ALU_SRA;
          else if (funct7 != FUNCT7_BASE)                    illegal = 1'b1;
        end
        OPC_OP_IMM: begin
          dec_o.alu_op = alu_op_from_funct3(funct3);
          dec_o.rd_we  = 1'b1;
          dec_o.b_sel  = B_SEL_IMM;
          dec_o.imm    = imm_i;
          // Shifts carry a zero-extended shamt; upper bits select SRA or are illegal
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_o.imm = {27'b0, instr_i[24:20]};
            if (funct3 == 3'b101 && funct7 == FUNCT7_ALT) dec_o.alu_op = ALU_SRA;
            else if (funct7 != FUNCT7_BASE)               illegal = 1'b1;
          end
        end
        OPC_LUI: begin
          dec_o.a_sel = A_SEL_ZERO;
          dec_o.b_sel = B_SEL_IMM;
          dec_o.imm   = imm_u;
          dec_o.rd_we = 1'b1;
        end
        OPC_AUIPC: begin
          dec_o.a_sel = A_SEL_PC;
          dec_o.b_sel = B_SEL_IMM;
          dec_o.imm   = imm_u;
          dec_o.rd_we = 1'b1;
        end
        OPC_JAL: begin
          dec_o.a_sel = A_SEL_PC;
          dec_o.b_sel = B_SEL_FOUR;
          dec_o.imm   = imm_j;
          dec_o.jal   = 1'b1;
          dec_o.rd_we = 1'b1;
        end
        OPC_JALR: begin
          dec_o.a_sel = A_SEL_PC;
          dec_o.b_sel = B_SEL_FOUR;
          dec_o.imm   = imm_i;
          dec_o.jalr  = 1'b1;
          dec_o.rd_we = 1'b1;
        end
        OPC_BRANCH: begin
          dec_o.branch = 1'b1;
          dec_o.imm    = imm_b;
          case (funct3)
            3'b000:  dec_o.alu_op = ALU_EQ;
            3'b001:  dec_o.alu_op = ALU_NE;
            3'b100:  dec_o.alu_op = ALU_LTS;
            3'b101:  dec_o.alu_op = ALU_GES;
            3'b110:  dec_o.alu_op = ALU_LTU;
            3'b111:  dec_o.alu_op = ALU_GEU;
            default: illegal = 1'b1;
          endcase
        end
        OPC_LOAD: begin
          dec_o.b_sel    = B_SEL_IMM;
          dec_o.imm      = imm_i;
          dec_o.mem_req  = 1'b1;
          dec_o.mem_size = funct3;
          dec_o.rd_we    = 1'b1;
        end
        OPC_STORE: begin
          dec_o.b_sel    = B_SEL_IMM;
          dec_o.imm      = imm_s;
          dec_o.mem_req  = 1'b1;
          dec_o.mem_we   = 1'b1;
          dec_o.mem_size = funct3;
        end
        default: illegal = 1'b1;
      endcase
    end

    // Illegal instructions must have no architectural side effects
    if (illegal) begin
      dec_o.rd_we   = 1'b0;
      dec_o.mem_req = 1'b0;
      dec_o.mem_we  = 1'b0;
      dec_o.branch  = 1'b0;
      dec_o.jal     = 1'b0;
      dec_o.jalr    = 1'b0;
    end
    if (dec_o.rd == 5'd0) dec_o.rd_we = 1'b0;
    dec_o.illegal = illegal;
  end

endmodule

// File: rtl/miriscv_decode_stage.sv
// Decode stage: decodes each accepted instruction and holds the bundle in a
// 2-entry skid buffer so every output comes straight from a register.
// Ports: clk_i/rst_i (sync active-high), flush_i; fetch side in_valid_i/
// in_ready_o/in_instr_i/in_pc_i; execute side out_valid_o/out_ready_i and
// the decoded bundle fields (alu_op_o ... pc_o).
module miriscv_decode_stage
  import miriscv_decode_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_instr_i,
  input  logic [31:0] in_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  alu_op_o,
  output logic [1:0]  a_sel_o,
  output logic [1:0]  b_sel_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [2:0]  mem_size_o,
  output logic        branch_o,
  output logic        jal_o,
  output logic        jalr_o,
  output logic        illegal_o,
  output logic [31:0] pc_o
);

  decode_t dec;
  decode_t head_q;
  decode_t tail_q;
  state_t  state_q, state_d;
  logic    in_ready_q, out_valid_q;
  logic    in_xfer, out_xfer;
  logic    load_head_dec, load_head_tail, load_tail;

  miriscv_decoder u_decoder (
    .instr_i (in_instr_i),
    .pc_i    (in_pc_i),
    .dec_o   (dec)
  );

  assign in_xfer  = in_valid_i & in_ready_q;
  assign out_xfer = out_valid_q & out_ready_i;

  // Next state and buffer load controls
  always_comb begin
    state_d        = state_q;
    load_head_dec  = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d       = ST_ONE;
            load_head_dec = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d   = ST_TWO;
            load_tail = 1'b1;
          end else if (!in_xfer && out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer && out_xfer) begin
            load_head_dec = 1'b1;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d        = ST_ONE;
            load_head_tail = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register with handshake flags derived from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Bundle storage: head is presented, tail is the skid slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_dec)       head_q <= dec;
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail)           tail_q <= dec;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign alu_op_o    = head_q.alu_op;
  assign a_sel_o     = head_q.a_sel;
  assign b_sel_o     = head_q.b_sel;
  assign imm_o       = head_q.imm;
  assign rs1_o       = head_q.rs1;
  assign rs2_o       = head_q.rs2;
  assign rd_o        = head_q.rd;
  assign rd_we_o     = head_q.rd_we;
  assign mem_req_o   = head_q.mem_req;
  assign mem_we_o    = head_q.mem_we;
  assign mem_size_o  = head_q.mem_size;
  assign branch_o    = head_q.branch;
  assign jal_o       = head_q.jal;
  assign jalr_o      = head_q.jalr;
  assign illegal_o   = head_q.illegal;
  assign pc_o        = head_q.pc;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Self-checking bench for miriscv_decode_stage: a reference decoder feeds a
// scoreboard queue on every input transfer; output transfers pop and compare.
module tb_miriscv_decode_stage;
  import miriscv_decode_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] in_instr_i, in_pc_i;
  logic [3:0]  alu_op_o;
  logic [1:0]  a_sel_o, b_sel_o;
  logic [31:0] imm_o, pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        rd_we_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o, illegal_o;
  logic [2:0]  mem_size_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_out    = 0;
  decode_t     sb[$];
  decode_t     cur, stall_b;
  bit          stall_q = 1'b0;

  miriscv_decode_stage u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_op_o(alu_op_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o), .imm_o(imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
    .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
    .illegal_o(illegal_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic decode_t observed();
    decode_t o;
    o.alu_op = alu_op_o;   o.a_sel = a_sel_o;     o.b_sel = b_sel_o;
    o.imm = imm_o;         o.rs1 = rs1_o;         o.rs2 = rs2_o;
    o.rd = rd_o;           o.rd_we = rd_we_o;     o.mem_req = mem_req_o;
    o.mem_we = mem_we_o;   o.mem_size = mem_size_o; o.branch = branch_o;
    o.jal = jal_o;         o.jalr = jalr_o;       o.illegal = illegal_o;
    o.pc = pc_o;
    return o;
  endfunction

  // Reference decoder written straight from the RV32I encodings
  function automatic decode_t model(input logic [31:0] ins, input logic [31:0] pc);
    decode_t     e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii, is, ib, iu, ij;
    logic        bad;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = 32'($signed(ins) >>> 20);
    is = {ii[31:5], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h000};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    e = '0;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.pc = pc;
    bad = 1'b0;
    if (ins[1:0] != 2'b11) bad = 1'b1;
    else if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      e.rd_we = 1'b1;
      case (f3)
        3'd0: e.alu_op = ALU_ADD;  3'd1: e.alu_op = ALU_SLL;
        3'd2: e.alu_op = ALU_SLTS; 3'd3: e.alu_op = ALU_SLTU;
        3'd4: e.alu_op = ALU_XOR;  3'd5: e.alu_op = ALU_SRL;
        3'd6: e.alu_op = ALU_OR;   default: e.alu_op = ALU_AND;
      endcase
      if (ins[6:0] == 7'h33) begin
        if (f7 == 7'h20 && f3 == 3'd0)      e.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu_op = ALU_SRA;
        else if (f7 != 7'h00)               bad = 1'b1;
      end else begin
        e.b_sel = 2'd1;
        e.imm   = ii;
        if (f3 == 3'd1) begin
          e.imm = 32'(ins[24:20]);
          if (f7 != 7'h00) bad = 1'b1;
        end else if (f3 == 3'd5) begin
          e.imm = 32'(ins[24:20]);
          if (f7 == 7'h20) e.alu_op = ALU_SRA;
          else if (f7 != 7'h00) bad = 1'b1;
        end
      end
    end else begin
      case (ins[6:0])
        7'h37: begin e.a_sel = 2'd2; e.b_sel = 2'd1; e.imm = iu; e.rd_we = 1'b1; end
        7'h17: begin e.a_sel = 2'd1; e.b_sel = 2'd1; e.imm = iu; e.rd_we = 1'b1; end
        7'h6F: begin e.a_sel = 2'd1; e.b_sel = 2'd2; e.imm = ij; e.rd_we = 1'b1; e.jal = 1'b1; end
        7'h67: begin e.a_sel = 2'd1; e.b_sel = 2'd2; e.imm = ii; e.rd_we = 1'b1; e.jalr = 1'b1; end
        7'h03: begin e.b_sel = 2'd1; e.imm = ii; e.mem_req = 1'b1; e.mem_size = f3; e.rd_we = 1'b1; end
        7'h23: begin e.b_sel = 2'd1; e.imm = is; e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_size = f3; end
        7'h63: begin
          e.imm = ib;
          e.branch = 1'b1;
          case (f3)
            3'd0: e.alu_op = ALU_EQ;  3'd1: e.alu_op = ALU_NE;
            3'd4: e.alu_op = ALU_LTS; 3'd5: e.alu_op = ALU_GES;
            3'd6: e.alu_op = ALU_LTU; 3'd7: e.alu_op = ALU_GEU;
            default: bad = 1'b1;
          endcase
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      e.rd_we = 1'b0; e.mem_req = 1'b0; e.mem_we = 1'b0;
      e.branch = 1'b0; e.jal = 1'b0; e.jalr = 1'b0;
    end
    if (e.rd == 5'd0) e.rd_we = 1'b0;
    e.illegal = bad;
    return e;
  endfunction

  // Scoreboard monitor, sampling mid-cycle
  always @(negedge clk_i) begin
    cur = observed();
    if (rst_i || flush_i) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) check("stable", 128'({out_valid_o, cur}), 128'({1'b1, stall_b}));
      if (out_valid_o && out_ready_i) begin
        n_out++;
        if (sb.size() == 0) check("out_without_in", 128'(out_valid_o), 128'(0));
        else check("bundle", 128'(cur), 128'(sb.pop_front()));
      end
      if (in_valid_i && in_ready_o) sb.push_back(model(in_instr_i, in_pc_i));
      stall_q = out_valid_o && !out_ready_i;
      stall_b = cur;
    end
  end

  // Offer one instruction until accepted; call and return at posedge+1
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit rand_rdy);
    bit acc = 1'b0;
    in_valid_i = 1'b1; in_instr_i = ins; in_pc_i = pc;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    check("accept", 128'(acc), 128'(1));
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (!out_valid_o) break;
    end
    check("drain_valid", 128'(out_valid_o), 128'(0));
    check("drain_sb", 128'(sb.size()), 128'(0));
    @(posedge clk_i); #1;
  endtask

  // Two back-to-back accepts with execute stalled; ends in state TWO
  task automatic fill_two(input logic [31:0] pc0);
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_instr_i = 32'h00500093;
    in_pc_i = pc0;         @(posedge clk_i); #1;
    in_pc_i = pc0 + 32'd4; @(posedge clk_i); #1;
  endtask

  logic [31:0] stream [16] = '{
    32'h123450B7, 32'h00001117, 32'h008001EF, 32'h00408267,
    32'h0040A283, 32'h0020A223, 32'h00209463, 32'h0020E333,
    32'h02009093, 32'h0020A013, 32'h022081B3, 32'h0020A463,
    32'h00000013, 32'h00000001, 32'hFFF00093, 32'hFE20DCE3
  };
  int unsigned base;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_instr_i = '0; in_pc_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 128'(out_valid_o), 128'(0));
    check("rst_ready", 128'(in_ready_o), 128'(1));
    check("rst_bundle", 128'(observed()), 128'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Directed decodes with execute always ready
    out_ready_i = 1'b1;
    send(32'h00500093, 32'h100, 1'b0); @(negedge clk_i);
    check("addi_valid", 128'(out_valid_o), 128'(1));
    check("addi", 128'({alu_op_o, b_sel_o, imm_o, rd_o, rd_we_o}), 128'({ALU_ADD, 2'd1, 32'd5, 5'd1, 1'b1}));
    @(posedge clk_i); #1;
    send(32'h402081B3, 32'h104, 1'b0); @(negedge clk_i);
    check("sub", 128'({alu_op_o, a_sel_o, b_sel_o, rd_o}), 128'({ALU_SUB, 2'd0, 2'd0, 5'd3}));
    @(posedge clk_i); #1;
    send(32'h4030D093, 32'h108, 1'b0); @(negedge clk_i);
    check("srai", 128'({alu_op_o, imm_o}), 128'({ALU_SRA, 32'd3}));
    @(posedge clk_i); #1;
    send(32'h00208463, 32'h10C, 1'b0); @(negedge clk_i);
    check("beq", 128'({branch_o, alu_op_o, imm_o, rd_we_o}), 128'({1'b1, ALU_EQ, 32'd8, 1'b0}));
    @(posedge clk_i); #1;
    send(32'h00000000, 32'h110, 1'b0); @(negedge clk_i);
    check("zero_word", 128'({illegal_o, rd_we_o}), 128'({1'b1, 1'b0}));
    @(posedge clk_i); #1;
    drain();

    // Backpressure: third offer refused, then in-order release
    base = n_out;
    fill_two(32'h200);
    in_pc_i = 32'h208;
    @(negedge clk_i);
    check("full_ready", 128'(in_ready_o), 128'(0));
    check("full_head_pc", 128'({out_valid_o, pc_o}), 128'({1'b1, 32'h200}));
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    drain();
    check("drain_count", 128'(n_out - base), 128'(2));

    // Flush in TWO with a concurrent offer
    base = n_out;
    fill_two(32'h300);
    flush_i = 1'b1; in_pc_i = 32'h30C;
    @(posedge clk_i); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush2_valid", 128'(out_valid_o), 128'(0));
    check("flush2_ready", 128'(in_ready_o), 128'(1));
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("flush2_emitted", 128'(n_out - base), 128'(0));
    @(posedge clk_i); #1;

    // Flush in ONE while an offer is accepted the same cycle
    base = n_out;
    out_ready_i = 1'b0;
    send(32'h00500093, 32'h320, 1'b0);
    in_valid_i = 1'b1; in_pc_i = 32'h324; flush_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("flush1_valid", 128'(out_valid_o), 128'(0));
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("flush1_emitted", 128'(n_out - base), 128'(0));
    @(posedge clk_i); #1;

    // Reset (with a simultaneous flush) while in ONE
    out_ready_i = 1'b0;
    send(32'h00500093, 32'h400, 1'b0);
    rst_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    check("rst1_valid", 128'(out_valid_o), 128'(0));
    check("rst1_ready", 128'(in_ready_o), 128'(1));
    check("rst1_bundle", 128'(observed()), 128'(0));
    @(posedge clk_i); #1;

    // Mixed stream with random backpressure
    for (int i = 0; i < 16; i++) send(stream[i], 32'h1000 + 32'(i * 4), 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (i % 2 == 0) w[1:0] = 2'b11;
      send(w, 32'h2000 + 32'(i * 4), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
